// File: rtl/line_pkt_pkg.sv
// rtl/line_pkt_pkg.sv - shared types, constants and parameter checks for the line packet packer
package line_pkt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR_HI  = 3'd1,
      ST_HDR_LO  = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_CK_HI   = 3'd4,
      ST_CK_LO   = 3'd5
   } rd_state_e;

   localparam int HDR_BYTES = 2;
   localparam int CK_BYTES  = 2;

   function automatic bit pixel_bits_legal(input int pb);
      return (pb == 1) || (pb == 2) || (pb == 4) || (pb == 8);
   endfunction

endpackage

// File: rtl/line_packet_packer_if.sv
// rtl/line_packet_packer_if.sv - pixel input stream and packet byte output stream
interface line_packet_packer_if #(
   parameter int PIXEL_BITS = 1
) ();
   logic                  pix_valid;
   logic                  pix_vsync;
   logic [PIXEL_BITS-1:0] pix_data;
   logic [7:0]            out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_sol;
   logic                  out_eol;

   modport slave (
      input  pix_valid, pix_vsync, pix_data, out_ready,
      output out_data, out_valid, out_sol, out_eol
   );

   modport master (
      output pix_valid, pix_vsync, pix_data, out_ready,
      input  out_data, out_valid, out_sol, out_eol
   );
endinterface

// File: rtl/line_pingpong_ram.sv
// rtl/line_pingpong_ram.sv - two-bank line store, one write port and one synchronous read port
module line_pingpong_ram #(
   parameter int LINE_BYTES = 160,
   parameter int ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              wr_bank_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [7:0]        wr_data_i,
   input  logic              rd_bank_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [7:0]        rd_data_o
);
   logic [7:0] mem_q [2][LINE_BYTES];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
      end
      rd_data_o <= mem_q[rd_bank_i][rd_addr_i];
   end
endmodule

// File: rtl/line_packet_packer.sv
// rtl/line_packet_packer.sv - packs pixels into ping-pong line buffers and emits one header-tagged packet per line
// Optional macro LINE_CHECKSUM_EN appends a 16-bit sum of header and payload bytes to each packet.
module line_packet_packer
   import line_pkt_pkg::*;
#(
   parameter int IMAGE_WIDTH  = 1280,
   parameter int IMAGE_HEIGHT = 720,
   parameter int PIXEL_BITS   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   line_packet_packer_if.slave bus,
   output logic                overflow,
   output logic [15:0]         drop_cnt
);
   localparam int LINE_BYTES = IMAGE_WIDTH * PIXEL_BITS / 8;
   localparam int PPB        = 8 / PIXEL_BITS;
   localparam int SH         = $clog2(PPB);
   localparam int PW         = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int ADDR_W     = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
   localparam int CW         = $clog2(LINE_BYTES + 1);
`ifdef LINE_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   if (!pixel_bits_legal(PIXEL_BITS)) begin : g_bad_pixel_bits
      $error("PIXEL_BITS must be 1, 2, 4 or 8");
   end
   if (((IMAGE_WIDTH * PIXEL_BITS) % 8) != 0 || IMAGE_HEIGHT < 1) begin : g_bad_geometry
      $error("IMAGE_WIDTH*PIXEL_BITS must be a multiple of 8 and IMAGE_HEIGHT positive");
   end

   logic            vsync_q;
   logic [PW-1:0]   pix_cnt_q, pix_cnt_d, pix_cnt_e;
   logic [7:0]      shift_q, shift_d, shift_e, byte_w;
   logic [15:0]     line_cnt_q, line_cnt_d, line_cnt_e;
   logic            dropping_q, dropping_d, dropping_e;
   logic            wr_bank_q, wr_bank_d;
   logic [1:0]      full_q, full_d;
   logic [1:0][15:0] tag_q;
   logic            overflow_q;
   logic [15:0]     drop_cnt_q;
   logic            vs_rise, first_pix, last_pix, drop_now, we, commit, drop_start;
   logic [ADDR_W-1:0] wr_addr;

   rd_state_e       state_q, state_d;
   logic            rd_bank_q, rd_bank_d;
   logic [CW-1:0]   rd_addr_q, rd_addr_d;
   logic [7:0]      rd_data;
   logic [7:0]      out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d, out_sol_q, out_sol_d, out_eol_q, out_eol_d;
   logic            hs, release_bank;
`ifdef LINE_CHECKSUM_EN
   logic [15:0]     sum_q, sum_d, sum_next;
`endif

   // A vsync edge clears the write side first, so a pixel in the same cycle starts line 0.
   always_comb begin
      vs_rise    = bus.pix_vsync & ~vsync_q;
      pix_cnt_e  = vs_rise ? '0 : pix_cnt_q;
      shift_e    = vs_rise ? '0 : shift_q;
      line_cnt_e = vs_rise ? '0 : line_cnt_q;
      dropping_e = vs_rise ? 1'b0 : dropping_q;
      first_pix  = (pix_cnt_e == '0);
      last_pix   = (pix_cnt_e == PW'(IMAGE_WIDTH - 1));
      drop_now   = first_pix ? full_q[wr_bank_q] : dropping_e;
      byte_w     = (shift_e << PIXEL_BITS) | 8'(bus.pix_data);
      we         = bus.pix_valid & ((pix_cnt_e & PW'(PPB - 1)) == PW'(PPB - 1)) & ~drop_now;
      wr_addr    = ADDR_W'(pix_cnt_e >> SH);
      commit     = bus.pix_valid & last_pix & ~drop_now;
      drop_start = bus.pix_valid & first_pix & full_q[wr_bank_q];
      pix_cnt_d  = pix_cnt_e;
      shift_d    = shift_e;
      line_cnt_d = line_cnt_e;
      dropping_d = dropping_e;
      wr_bank_d  = commit ? ~wr_bank_q : wr_bank_q;
      if (bus.pix_valid) begin
         shift_d    = byte_w;
         pix_cnt_d  = last_pix ? '0 : pix_cnt_e + PW'(1);
         line_cnt_d = last_pix ? line_cnt_e + 16'd1 : line_cnt_e;
         dropping_d = last_pix ? 1'b0 : drop_now;
      end
   end

   line_pingpong_ram #(.LINE_BYTES(LINE_BYTES), .ADDR_W(ADDR_W)) u_ram (
      .clk       (clk),
      .we_i      (we),
      .wr_bank_i (wr_bank_q),
      .wr_addr_i (wr_addr),
      .wr_data_i (byte_w),
      .rd_bank_i (rd_bank_d),
      .rd_addr_i (ADDR_W'(rd_addr_d)),
      .rd_data_o (rd_data)
   );

   // The RAM is addressed with next-state values so the byte for rd_addr_q is ready for the next handshake.
   always_comb begin
      hs           = out_valid_q & bus.out_ready;
      state_d      = state_q;
      rd_bank_d    = rd_bank_q;
      rd_addr_d    = rd_addr_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_sol_d    = out_sol_q;
      out_eol_d    = out_eol_q;
      release_bank = 1'b0;
`ifdef LINE_CHECKSUM_EN
      sum_next     = sum_q + {8'h00, out_data_q};
      sum_d        = sum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            rd_addr_d = '0;
            if (full_q[rd_bank_q]) begin
               state_d     = ST_HDR_HI;
               out_valid_d = 1'b1;
               out_data_d  = tag_q[rd_bank_q][15:8];
               out_sol_d   = 1'b1;
               out_eol_d   = 1'b0;
`ifdef LINE_CHECKSUM_EN
               sum_d       = '0;
`endif
            end
         end
         ST_HDR_HI: if (hs) begin
            state_d    = ST_HDR_LO;
            out_data_d = tag_q[rd_bank_q][7:0];
            out_sol_d  = 1'b0;
`ifdef LINE_CHECKSUM_EN
            sum_d      = sum_next;
`endif
         end
         ST_HDR_LO: if (hs) begin
            state_d    = ST_PAYLOAD;
            out_data_d = rd_data;
            rd_addr_d  = CW'(1);
            out_eol_d  = !CK_EN && (LINE_BYTES == 1);
`ifdef LINE_CHECKSUM_EN
            sum_d      = sum_next;
`endif
         end
         ST_PAYLOAD: if (hs) begin
`ifdef LINE_CHECKSUM_EN
            sum_d = sum_next;
`endif
            if (rd_addr_q == CW'(LINE_BYTES)) begin
`ifdef LINE_CHECKSUM_EN
               state_d    = ST_CK_HI;
               out_data_d = sum_next[15:8];
               out_eol_d  = 1'b0;
`else
               state_d      = ST_IDLE;
               out_valid_d  = 1'b0;
               out_eol_d    = 1'b0;
               rd_addr_d    = '0;
               rd_bank_d    = ~rd_bank_q;
               release_bank = 1'b1;
`endif
            end else begin
               out_data_d = rd_data;
               rd_addr_d  = rd_addr_q + CW'(1);
               out_eol_d  = !CK_EN && (rd_addr_q == CW'(LINE_BYTES - 1));
            end
         end
`ifdef LINE_CHECKSUM_EN
         ST_CK_HI: if (hs) begin
            state_d    = ST_CK_LO;
            out_data_d = sum_q[7:0];
            out_eol_d  = 1'b1;
         end
         ST_CK_LO: if (hs) begin
            state_d      = ST_IDLE;
            out_valid_d  = 1'b0;
            out_eol_d    = 1'b0;
            rd_addr_d    = '0;
            rd_bank_d    = ~rd_bank_q;
            release_bank = 1'b1;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      full_d = full_q;
      if (commit)       full_d[wr_bank_q] = 1'b1;
      if (release_bank) full_d[rd_bank_q] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q     <= 1'b0;
         pix_cnt_q   <= '0;
         shift_q     <= '0;
         line_cnt_q  <= '0;
         dropping_q  <= 1'b0;
         wr_bank_q   <= 1'b0;
         full_q      <= '0;
         tag_q       <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
         state_q     <= ST_IDLE;
         rd_bank_q   <= 1'b0;
         rd_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sol_q   <= 1'b0;
         out_eol_q   <= 1'b0;
`ifdef LINE_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         vsync_q     <= bus.pix_vsync;
         pix_cnt_q   <= pix_cnt_d;
         shift_q     <= shift_d;
         line_cnt_q  <= line_cnt_d;
         dropping_q  <= dropping_d;
         wr_bank_q   <= wr_bank_d;
         full_q      <= full_d;
         if (commit) tag_q[wr_bank_q] <= line_cnt_e;
         if (drop_start) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
         end
         state_q     <= state_d;
         rd_bank_q   <= rd_bank_d;
         rd_addr_q   <= rd_addr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sol_q   <= out_sol_d;
         out_eol_q   <= out_eol_d;
`ifdef LINE_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sol   = out_sol_q;
   assign bus.out_eol   = out_eol_q;
   assign overflow      = overflow_q;
   assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_line_packet_packer.sv
// tb/tb_line_packet_packer.sv - directed self-checking bench for line_packet_packer (16-pixel 1-bit lines)
module tb_line_packet_packer;
   localparam int W  = 16;
   localparam int PB = 1;
`ifdef LINE_CHECKSUM_EN
   localparam int PKT = 6;
`else
   localparam int PKT = 4;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        overflow;
   logic [15:0] drop_cnt;

   line_packet_packer_if #(.PIXEL_BITS(PB)) bus ();

   line_packet_packer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(720), .PIXEL_BITS(PB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .overflow (overflow),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   logic [7:0] rx_data[$];
   bit         rx_sol[$];
   bit         rx_eol[$];
   int         cyc = 0;
   int         last_pix_cyc = 0;
   int         valid_rise_cyc = -1;
   int         stab_err = 0;
   bit         prev_valid = 0;
   bit         prev_stall = 0;
   logic [7:0] prev_data;
   bit         prev_sol, prev_eol;

   // Handshakes are sampled mid-cycle; a stalled byte must reappear unchanged one cycle later.
   always @(negedge clk) begin
      if (rst_n) begin
         cyc++;
         if (bus.pix_valid) last_pix_cyc = cyc;
         if (bus.out_valid && !prev_valid) valid_rise_cyc = cyc;
         if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data ||
                            bus.out_sol !== prev_sol || bus.out_eol !== prev_eol))
            stab_err++;
         if (bus.out_valid && bus.out_ready) begin
            rx_data.push_back(bus.out_data);
            rx_sol.push_back(bus.out_sol);
            rx_eol.push_back(bus.out_eol);
         end
         prev_valid = bus.out_valid;
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_sol   = bus.out_sol;
         prev_eol   = bus.out_eol;
      end
   end

   task automatic drive(input bit v, input bit d, input bit vs);
      bus.pix_valid = v;
      bus.pix_data  = d;
      bus.pix_vsync = vs;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0);
   endtask

   task automatic vsync_pulse();
      drive(0, 0, 1);
      drive(0, 0, 0);
   endtask

   task automatic send_line(input logic [15:0] pattern, input bit vs_first);
      for (int i = 0; i < W; i++) drive(1, pattern[15-i], (i == 0) ? vs_first : 1'b0);
      bus.pix_valid = 1'b0;
      bus.pix_vsync = 1'b0;
   endtask

   task automatic expect_pkt(input string tag, input logic [15:0] idx, input logic [7:0] b0, input logic [7:0] b1);
      logic [7:0]  exp_b[6];
      logic [15:0] s;
      int          waited = 0;
      while (rx_data.size() < PKT && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_arrived"}, 32'(rx_data.size() >= PKT), 32'd1);
      if (rx_data.size() < PKT) return;
      exp_b[0] = idx[15:8];
      exp_b[1] = idx[7:0];
      exp_b[2] = b0;
      exp_b[3] = b1;
      s = 16'(idx[15:8]) + 16'(idx[7:0]) + 16'(b0) + 16'(b1);
      exp_b[4] = s[15:8];
      exp_b[5] = s[7:0];
      for (int i = 0; i < PKT; i++) begin
         check($sformatf("%s_byte%0d", tag, i), 32'(rx_data.pop_front()), 32'(exp_b[i]));
         check($sformatf("%s_sol%0d", tag, i), 32'(rx_sol.pop_front()), 32'(i == 0));
         check($sformatf("%s_eol%0d", tag, i), 32'(rx_eol.pop_front()), 32'(i == PKT - 1));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_vsync = 1'b0;
      bus.pix_data  = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_sol", 32'(bus.out_sol), 32'd0);
      check("rst_eol", 32'(bus.out_eol), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // Basic line with header, flags and commit-to-valid latency
      vsync_pulse();
      send_line(16'hAAAA, 0);
      expect_pkt("t1", 16'h0000, 8'hAA, 8'hAA);
      check("t1_latency", 32'(valid_rise_cyc - last_pix_cyc), 32'd2);
      idle(5);

      // Back-to-back lines; second line index 1
      vsync_pulse();
      send_line(16'h0F0F, 0);
      send_line(16'hFFFF, 0);
      expect_pkt("t2a", 16'h0000, 8'h0F, 8'h0F);
      expect_pkt("t2b", 16'h0001, 8'hFF, 8'hFF);
      idle(5);

      // Stalled consumer: third line dropped, order preserved, line index keeps counting
      bus.out_ready = 1'b0;
      vsync_pulse();
      send_line(16'h1234, 0);
      send_line(16'h5678, 0);
      send_line(16'h9ABC, 0);
      idle(2);
      check("t3_overflow", 32'(overflow), 32'd1);
      check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
      check("t3_nothing_yet", 32'(rx_data.size()), 32'd0);
      bus.out_ready = 1'b1;
      expect_pkt("t3a", 16'h0000, 8'h12, 8'h34);
      expect_pkt("t3b", 16'h0001, 8'h56, 8'h78);
      idle(4);
      send_line(16'hC3C3, 0);
      expect_pkt("t3c", 16'h0003, 8'hC3, 8'hC3);
      check("t3_overflow_sticky", 32'(overflow), 32'd1);
      check("t3_drop_cnt_after", 32'(drop_cnt), 32'd1);
      idle(5);

      // Partial line cut by vsync; vsync coincides with the new line's first pixel
      vsync_pulse();
      for (int i = 0; i < 7; i++) drive(1, 1, 0);
      idle(10);
      check("t4_no_partial", 32'(rx_data.size()), 32'd0);
      send_line(16'hF00F, 1);
      expect_pkt("t4", 16'h0000, 8'hF0, 8'h0F);
      idle(5);

      // Ready toggling every cycle while the packet drains
      stab_err = 0;
      vsync_pulse();
      fork
         send_line(16'h5AA5, 0);
         begin
            repeat (60) begin
               @(posedge clk);
               #1;
               bus.out_ready = ~bus.out_ready;
            end
         end
      join
      bus.out_ready = 1'b1;
      expect_pkt("t5", 16'h0000, 8'h5A, 8'hA5);
      check("t5_stable", 32'(stab_err), 32'd0);
      idle(10);
      check("end_no_extra", 32'(rx_data.size()), 32'd0);
      check("end_drop_cnt", 32'(drop_cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/line_packet_packer.md
Name: line_packet_packer

Overview:
Parametrised successor to the 1-bit Sobel line framing that feeds the UDP transmitter. It packs a per-pixel stream of PIXEL_BITS-wide pixels into bytes and stores each line in a ping-pong line buffer. Each completed line is emitted as a byte packet with a 2-byte line-index header, under valid/ready flow control. It sits between image_process_top and the ethernet payload source, entirely in the pixel clock domain. CDC to clk_eth stays in the ethernet block.

Parameters:
IMAGE_WIDTH, 1280, valid pixels per line; IMAGE_WIDTH*PIXEL_BITS must be a multiple of 8.
IMAGE_HEIGHT, 720, lines per frame; used only for the line-index range check in the bench.
PIXEL_BITS, 1, bits per pixel; legal values are 1, 2, 4 and 8. Any other value is an elaboration error.
LINE_BYTES, IMAGE_WIDTH*PIXEL_BITS/8, derived payload bytes per line; not to be overridden.

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pix_valid  in  1  pixel strobe; there is no backpressure on the input
pix_vsync  in  1  frame sync; a rising edge marks frame start
pix_data  in  PIXEL_BITS  pixel value
out_data  out  8  packet byte
out_valid  out  1  out_data is valid
out_ready  in  1  consumer accepts the byte when out_valid && out_ready
out_sol  out  1  qualifies the first byte of a packet (header high byte)
out_eol  out  1  qualifies the last byte of a packet
overflow  out  1  sticky; set when a line is dropped; cleared only by reset
drop_cnt  out  16  number of dropped lines; saturates at 16'hFFFF

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs are 0. Both banks are empty, all counters are 0, the write bank is 0 and the FSM is in IDLE.
- Packing:
  - Pixels are packed MSB-first: the first pixel of a byte occupies bits [7:8-PIXEL_BITS].
  - A byte is written to the buffer on the cycle its 8/PIXEL_BITS-th pixel is accepted.
- Line commit:
  - On the valid pixel that makes pix_cnt reach IMAGE_WIDTH, the write bank is marked full and tagged with line_cnt.
  - In that same cycle the write bank toggles, pix_cnt clears and line_cnt increments. line_cnt is 16 bits and wraps modulo 2^16.
- Overflow:
  - If the write bank is still full when a line starts (first pixel of a line), that line is dropped. Its pixels are not written and the bank is not committed.
  - line_cnt still increments for a dropped line, overflow is set, and drop_cnt increments.
- Frame start (pix_vsync rising edge, detected with a registered previous value):
  - pix_cnt, the pack shift register and line_cnt clear to 0, and any partial line is discarded.
  - Full banks and the read side are unaffected.
  - If a vsync edge and pix_valid occur in the same cycle, the clear is applied first, so that pixel becomes pixel 0 of line 0.
- Read FSM states: IDLE -> HDR_HI -> HDR_LO -> PAYLOAD -> (CK_HI -> CK_LO, only when LINE_CHECKSUM_EN is defined) -> IDLE.
  - IDLE moves to HDR_HI when the read bank is full.
  - Each state advances only on a handshake.
  - PAYLOAD issues LINE_BYTES bytes in address order.
  - On the last handshake the read bank is released (marked empty) and the read bank toggles.
  - Banks are always consumed in commit order.
- Header: HDR_HI carries line_idx[15:8] and HDR_LO carries line_idx[7:0].
- Flag placement: out_sol is asserted with HDR_HI. out_eol is asserted with the last payload byte, or with CK_LO when the checksum is enabled.
- Output stability: out_data, out_sol and out_eol are registered and held stable while out_valid && !out_ready. out_valid never drops without a handshake.
  - Line memory reads are synchronous, one cycle, with a prefetch/skid register so that back-to-back handshakes sustain one byte per cycle.
- Latency: the first out_valid for HDR_HI occurs exactly 2 clk cycles after the commit cycle, provided the FSM is in IDLE and the bank is free.
- Write/read collision: a commit of bank B and the release of bank B in the same cycle cannot happen, because the write side never writes a full bank. A release and a commit of the other bank in the same cycle are both honoured.

Optional Feature:
Macro LINE_CHECKSUM_EN.
- Defined: the packet is extended by CK_HI/CK_LO, carrying a 16-bit unsigned wrap-around sum of the header bytes and payload bytes. The sum is accumulated as the bytes are handshaken. Packet length is LINE_BYTES+4.
- Undefined: the CK states and the accumulator are absent. Packet length is LINE_BYTES+2.

Decomposition:
- Shared package line_pkt_pkg holds:
  - the FSM state enum;
  - the HDR_BYTES=2 and CK_BYTES=2 constants;
  - a PIXEL_BITS legality check function.
- One sub-module, line_pingpong_ram: two banks of LINE_BYTES x 8 bits with a single write port and a single synchronous read port, inferring BRAM.

Test Plan:
All scenarios use IMAGE_WIDTH=16, PIXEL_BITS=1 (LINE_BYTES=2) with out_ready held at 1 unless stated otherwise.
- Vsync pulse, then 16 pixels 1,0,1,0,... -> bytes 00,00,AA,AA; out_sol on byte 0, out_eol on byte 3; first out_valid 2 cycles after the 16th pixel.
- Two lines back-to-back, the second all ones -> second packet is 00,01,FF,FF.
- out_ready=0 for 40 cycles while 3 lines arrive -> lines 0 and 1 delivered in order; line 2 dropped; overflow=1, drop_cnt=1; the next accepted line has header 00,03.
- Vsync rising after 7 pixels of a line -> partial line discarded, no packet; the next full line has header 00,00.
- out_ready toggling every cycle during a packet -> out_data held stable across stalls; no byte duplicated or lost.
- With LINE_CHECKSUM_EN defined and payload AA,AA on line 0 -> checksum bytes 01,54; out_eol on the last checksum byte.
